// File: rtl/glb_pkg.sv
// glb_pkg: shared types and helpers for the banked global buffer.
//   load_state_t : load engine states (IDLE, LOAD, DONE)
//   lane_bits()  : width of the bank-select field for a given lane count
package glb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } load_state_t;

  function automatic int unsigned lane_bits(input int unsigned lanes);
    return $clog2(lanes);
  endfunction

endpackage

// File: rtl/single_RAM.sv
// single_RAM: one bank of the global buffer. One write port, one read port,
// registered read data that updates only on re and holds otherwise.
// Contents are not reset.
//   clk          : rising-edge clock
//   we/waddr/wdata : write port
//   re/raddr     : read request; rdata valid the cycle after re
//   rdata        : registered read data
module single_RAM #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 96,
  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/banked_glb.sv
// banked_glb: global buffer for bias/psum storage.
// FIFO words (FIFO_WIDTH) are accepted by a self-sequencing load engine and
// split across LANES banks at one row per word; the PE array reads single
// DATA_WIDTH elements with one cycle of latency.
//   core_clk, reset           : clock, synchronous active-high reset
//   load_start/base/words     : start a load of load_words rows from load_base
//   wr_valid/wr_ready/wr_data : FIFO word handshake
//   load_busy, load_done      : load in progress / one-cycle completion pulse
//   re/raddr                  : element read request
//   rdata/rvalid              : read data, valid the cycle after re
module banked_glb
  import glb_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 384,
  parameter int unsigned LANES      = FIFO_WIDTH / DATA_WIDTH,
  localparam int unsigned ADDR      = $clog2(DEPTH),
  localparam int unsigned ROWS      = DEPTH / LANES,
  localparam int unsigned RADDR     = $clog2(ROWS)
) (
  input  logic                  core_clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic [RADDR-1:0]      load_base,
  input  logic [RADDR:0]        load_words,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [FIFO_WIDTH-1:0] wr_data,
  output logic                  load_busy,
  output logic                  load_done,
  input  logic                  re,
  input  logic [ADDR-1:0]       raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid
);

  localparam int unsigned LANE_BITS = lane_bits(LANES);

  load_state_t          state_q, state_d;
  logic [RADDR-1:0]     wr_row_q, wr_row_d;
  logic [RADDR:0]       remaining_q, remaining_d;
  logic                 wr_fire;

  logic [LANE_BITS-1:0]  rd_bank;
  logic [RADDR-1:0]      rd_row;
  logic                  rd_oor;
  logic                  rd_fwd;
  logic [LANES-1:0]      bank_re;
  logic [DATA_WIDTH-1:0] wr_lane    [LANES];
  logic [DATA_WIDTH-1:0] bank_rdata [LANES];

  logic [LANE_BITS-1:0]  sel_q, sel_d;
  logic                  zero_q, zero_d;
  logic                  fwd_q, fwd_d;
  logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;
  logic                  rvalid_q, rvalid_d;

  // Load engine
  always_comb begin
    state_d     = state_q;
    wr_row_d    = wr_row_q;
    remaining_d = remaining_q;
    wr_ready    = 1'b0;
    load_busy   = 1'b0;
    load_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_start) begin
          if (load_words == '0) begin
            state_d = DONE;
          end else begin
            state_d     = LOAD;
            wr_row_d    = load_base;
            remaining_d = load_words;
          end
        end
      end
      LOAD: begin
        wr_ready  = 1'b1;
        load_busy = 1'b1;
        if (wr_valid) begin
          wr_row_d    = (wr_row_q == RADDR'(ROWS - 1)) ? '0 : wr_row_q + RADDR'(1);
          remaining_d = remaining_q - (RADDR + 1)'(1);
          if (remaining_q == (RADDR + 1)'(1)) state_d = DONE;
        end
      end
      DONE: begin
        load_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Writes are suppressed on the reset edge so a reset mid-load leaves the
  // array exactly as it stood after the last completed transfer.
  assign wr_fire = wr_valid && (state_q == LOAD) && !reset;

  // Read decode
  always_comb begin
    rd_bank = raddr[LANE_BITS-1:0];
    rd_row  = raddr[ADDR-1:LANE_BITS];
    rd_oor  = {1'b0, raddr} >= (ADDR + 1)'(DEPTH);
    rd_fwd  = re && !rd_oor && wr_fire && (rd_row == wr_row_q);
  end

  // The banks hold their read register when not selected, so the output mux
  // state (bank select, zero, forward) is held too; rdata then stays put on
  // idle cycles without a separate output register.
  always_comb begin
    sel_d      = sel_q;
    zero_d     = zero_q;
    fwd_d      = fwd_q;
    fwd_data_d = fwd_data_q;
    rvalid_d   = re;
    if (re) begin
      sel_d      = rd_bank;
      zero_d     = rd_oor;
      fwd_d      = rd_fwd;
      fwd_data_d = wr_lane[rd_bank];
    end
  end

  always_ff @(posedge core_clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_row_q    <= '0;
      remaining_q <= '0;
      sel_q       <= '0;
      zero_q      <= 1'b1;
      fwd_q       <= 1'b0;
      fwd_data_q  <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_row_q    <= wr_row_d;
      remaining_q <= remaining_d;
      sel_q       <= sel_d;
      zero_q      <= zero_d;
      fwd_q       <= fwd_d;
      fwd_data_q  <= fwd_data_d;
      rvalid_q    <= rvalid_d;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_bank
    assign wr_lane[i] = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
    assign bank_re[i] = re && !rd_oor && (rd_bank == LANE_BITS'(i));

    single_RAM #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (ROWS)
    ) u_bank (
      .clk   (core_clk),
      .we    (wr_fire),
      .waddr (wr_row_q),
      .wdata (wr_lane[i]),
      .re    (bank_re[i]),
      .raddr (rd_row),
      .rdata (bank_rdata[i])
    );
  end

  assign rdata  = zero_q ? '0 : (fwd_q ? fwd_data_q : bank_rdata[sel_q]);
  assign rvalid = rvalid_q;

endmodule

// File: tb/tb_banked_glb.sv
// tb_banked_glb: directed scenarios plus randomized traffic for banked_glb,
// checked every cycle against an element-level reference model.
module tb_banked_glb;

  localparam int FW    = 64;
  localparam int DW    = 16;
  localparam int DEPTH = 384;
  localparam int LANES = 4;
  localparam int ROWS  = 96;

  logic          core_clk = 1'b0;
  logic          reset;
  logic          load_start;
  logic [6:0]    load_base;
  logic [7:0]    load_words;
  logic          wr_valid;
  logic          wr_ready;
  logic [FW-1:0] wr_data;
  logic          load_busy;
  logic          load_done;
  logic          re;
  logic [8:0]    raddr;
  logic [DW-1:0] rdata;
  logic          rvalid;

  banked_glb #(
    .FIFO_WIDTH (FW),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .core_clk   (core_clk),
    .reset      (reset),
    .load_start (load_start),
    .load_base  (load_base),
    .load_words (load_words),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .re         (re),
    .raddr      (raddr),
    .rdata      (rdata),
    .rvalid     (rvalid)
  );

  always #5 core_clk = ~core_clk;

  // Reference model: element memory plus abstract load progress
  logic [DW-1:0] m_mem   [DEPTH];
  bit            m_known [DEPTH];
  bit            m_loading;
  bit            m_done;
  int            m_left;
  int            m_row;
  bit            m_rvalid;
  logic [DW-1:0] m_rdata;
  bit            m_rd_known;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Check this cycle's outputs, advance the model by one edge, then clock.
  task automatic step();
    bit            fire;
    int            row;
    int            lane;
    logic [DW-1:0] rd;
    bit            rdk;
    #1;
    chk("wr_ready", wr_ready, m_loading);
    chk("load_busy", load_busy, m_loading);
    chk("load_done", load_done, m_done);
    chk("rvalid", rvalid, m_rvalid);
    if (m_rd_known) chk("rdata", rdata, m_rdata);

    fire = m_loading && wr_valid;
    rd   = m_rdata;
    rdk  = m_rd_known;
    if (re) begin
      if (int'(raddr) >= DEPTH) begin
        rd  = '0;
        rdk = 1'b1;
      end else begin
        row  = int'(raddr) / LANES;
        lane = int'(raddr) % LANES;
        if (fire && row == m_row) begin
          rd  = wr_data[lane*DW +: DW];
          rdk = 1'b1;
        end else begin
          rd  = m_mem[raddr];
          rdk = m_known[raddr];
        end
      end
    end

    if (reset) begin
      m_loading  = 1'b0;
      m_done     = 1'b0;
      m_row      = 0;
      m_left     = 0;
      m_rvalid   = 1'b0;
      m_rdata    = '0;
      m_rd_known = 1'b1;
    end else begin
      m_rvalid   = re;
      m_rdata    = rd;
      m_rd_known = rdk;
      if (m_done) begin
        m_done = 1'b0;
      end else if (m_loading) begin
        if (fire) begin
          for (int i = 0; i < LANES; i++) begin
            m_mem[m_row*LANES + i]   = wr_data[i*DW +: DW];
            m_known[m_row*LANES + i] = 1'b1;
          end
          m_row  = (m_row + 1) % ROWS;
          m_left = m_left - 1;
          if (m_left == 0) begin
            m_loading = 1'b0;
            m_done    = 1'b1;
          end
        end
      end else if (load_start) begin
        if (load_words == 0) begin
          m_done = 1'b1;
        end else begin
          m_loading = 1'b1;
          m_row     = int'(load_base);
          m_left    = int'(load_words);
        end
      end
    end
    @(posedge core_clk);
    #1;
  endtask

  task automatic start_load(input int base, input int words);
    load_start = 1'b1;
    load_base  = 7'(base);
    load_words = 8'(words);
    step();
    load_start = 1'b0;
  endtask

  task automatic rd_check(input string tag, input int addr, input logic [DW-1:0] exp);
    re    = 1'b1;
    raddr = 9'(addr);
    step();
    re    = 1'b0;
    chk({tag, "_rvalid"}, rvalid, 1'b1);
    chk(tag, rdata, exp);
  endtask

  logic [FW-1:0] w1, w2;

  initial begin
    reset      = 1'b1;
    load_start = 1'b0;
    load_base  = '0;
    load_words = '0;
    wr_valid   = 1'b0;
    wr_data    = '0;
    re         = 1'b0;
    raddr      = '0;
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
    m_loading = 0; m_done = 0; m_row = 0; m_left = 0;
    m_rvalid = 0; m_rdata = '0; m_rd_known = 1'b1;
    @(posedge core_clk);
    @(posedge core_clk);
    #1;
    step();
    reset = 1'b0;
    chk("reset_rdata", rdata, 16'h0);
    step();

    // Basic two-word load with wr_valid held, then sequential reads
    start_load(0, 2);
    wr_valid = 1'b1;
    wr_data  = 64'h0004_0003_0002_0001;
    step();
    wr_data  = 64'h0008_0007_0006_0005;
    step();
    wr_valid = 1'b0;
    chk("basic_done", load_done, 1'b1);
    step();
    for (int i = 0; i < 8; i++) rd_check("seq_rd", i, 16'(i + 1));
    step();
    chk("hold_rvalid", rvalid, 1'b0);
    chk("hold_rdata", rdata, 16'h8);

    // Three-word load with wr_valid toggling
    start_load(20, 3);
    for (int k = 0; k < 6; k++) begin
      wr_valid = (k % 2 == 0);
      wr_data  = {$urandom, $urandom};
      step();
    end
    wr_valid = 1'b0;
    step();

    // Wrap from the last row to row 0
    w1 = {$urandom, $urandom};
    w2 = {$urandom, $urandom};
    start_load(ROWS - 1, 2);
    wr_valid = 1'b1;
    wr_data  = w1;
    step();
    wr_data  = w2;
    step();
    wr_valid = 1'b0;
    step();
    for (int i = 0; i < 4; i++) rd_check("wrap_hi", 380 + i, w1[i*DW +: DW]);
    for (int i = 0; i < 4; i++) rd_check("wrap_lo", i, w2[i*DW +: DW]);

    // Read of the row being written in the same cycle
    start_load(10, 1);
    wr_valid = 1'b1;
    wr_data  = 64'h1234_BEEF_5678_9ABC;
    rd_check("fwd", 4*10 + 2, 16'hBEEF);
    wr_valid = 1'b0;
    step();
    rd_check("fwd_array", 4*10 + 2, 16'hBEEF);

    // Out-of-range read
    rd_check("oor", 400, 16'h0);

    // Zero-word load: done next cycle, offered data is not written
    w1 = {$urandom, $urandom};
    start_load(30, 1);
    wr_valid = 1'b1;
    wr_data  = w1;
    step();
    wr_valid = 1'b0;
    step();
    wr_valid = 1'b1;
    wr_data  = ~w1;
    start_load(30, 0);
    chk("zero_done", load_done, 1'b1);
    step();
    step();
    wr_valid = 1'b0;
    for (int i = 0; i < 4; i++) rd_check("zero_nowrite", 120 + i, w1[i*DW +: DW]);

    // Reset after the first of four transfers
    w1 = {$urandom, $urandom};
    start_load(50, 4);
    wr_valid = 1'b1;
    wr_data  = w1;
    step();
    wr_valid = 1'b0;
    reset    = 1'b1;
    step();
    reset    = 1'b0;
    chk("rst_wr_ready", wr_ready, 1'b0);
    chk("rst_busy", load_busy, 1'b0);
    for (int i = 0; i < 3; i++) step();
    for (int i = 0; i < 4; i++) rd_check("rst_keep", 200 + i, w1[i*DW +: DW]);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(0, 299) == 0);
      load_start = ($urandom_range(0, 5) == 0);
      load_base  = 7'($urandom_range(0, ROWS - 1));
      load_words = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                               : 8'($urandom_range(0, 8));
      wr_valid   = $urandom_range(0, 2) != 0;
      wr_data    = {$urandom, $urandom};
      re         = $urandom_range(0, 1) != 0;
      raddr      = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(DEPTH, 511))
                                               : 9'($urandom_range(0, DEPTH - 1));
      step();
    end
    reset = 1'b0; load_start = 1'b0; wr_valid = 1'b0; re = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
